vx_index_decoder: RTL

- Registered, flow-controlled inverse of the priority encoder: converts a stream of (index, enable) pairs into one-hot bitmasks.
- Used where a selected lane, bank or slot index is expanded back into a select or grant mask, e.g. scheduler grant to per-warp enable.
- Valid/ready on both sides; a 2-entry elastic buffer (output register plus skid register) gives full throughput under backpressure.

---
 rtl/vx_index_decoder.sv | 117 +++++++++++
 1 files changed

// File: rtl/vx_index_decoder.sv
// Registered index-to-one-hot decoder with a 2-entry elastic buffer.
// Define VX_INDEX_DECODER_THERMO_EN to add the thermometer-mask output.
module vx_index_decoder #(
  parameter int DATAW  = 8,
  parameter int LDATAW = (DATAW > 1) ? $clog2(DATAW) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [LDATAW-1:0] index_in,
  input  logic              enable_in,
  output logic              ready_in,
  output logic              valid_out,
  output logic [DATAW-1:0]  data_out,
  output logic              range_err_out,
`ifdef VX_INDEX_DECODER_THERMO_EN
  output logic [DATAW-1:0]  thermo_out,
`endif
  input  logic              ready_out
);

  int               idx;
  logic [DATAW-1:0] dec_d;
  logic             dec_e;

  logic             ov;
  logic [DATAW-1:0] od;
  logic             oe;
  logic             sv;
  logic [DATAW-1:0] sd;
  logic             se;

  logic             out_free;
  logic             take;

  assign idx = int'(index_in);

  always_comb begin
    dec_d = '0;
    for (int i = 0; i < DATAW; i++) begin
      dec_d[i] = enable_in && (idx == i);
    end
  end

  assign dec_e = enable_in && (idx >= DATAW);

`ifdef VX_INDEX_DECODER_THERMO_EN
  logic [DATAW-1:0] dec_t;
  logic [DATAW-1:0] ot;
  logic [DATAW-1:0] st;

  // Out-of-range index saturates to all-ones since idx exceeds every bit.
  always_comb begin
    dec_t = '0;
    for (int i = 0; i < DATAW; i++) begin
      dec_t[i] = enable_in && (idx >= i);
    end
  end
`endif

  assign out_free = !ov || ready_out;
  assign take     = valid_in && !sv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ov <= 1'b0;
      od <= '0;
      oe <= 1'b0;
      sv <= 1'b0;
      sd <= '0;
      se <= 1'b0;
    end else if (out_free) begin
      if (sv) begin
        ov <= 1'b1;
        od <= sd;
        oe <= se;
        sv <= 1'b0;
      end else if (valid_in) begin
        ov <= 1'b1;
        od <= dec_d;
        oe <= dec_e;
      end else begin
        ov <= 1'b0;
      end
    end else if (take) begin
      sv <= 1'b1;
      sd <= dec_d;
      se <= dec_e;
    end
  end

`ifdef VX_INDEX_DECODER_THERMO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ot <= '0;
      st <= '0;
    end else if (out_free) begin
      if (sv) begin
        ot <= st;
      end else if (valid_in) begin
        ot <= dec_t;
      end
    end else if (take) begin
      st <= dec_t;
    end
  end

  assign thermo_out = ot;
`endif

  // Registered-only ready: no combinational path from ready_out.
  assign ready_in      = !sv;
  assign valid_out     = ov;
  assign data_out      = od;
  assign range_err_out = oe;

endmodule
